genius_sequencer: RTL and testbench

Control state machine for the memory-game datapath. It paces each game: setup, FPGA sequence display, user entry with timeout, per-press check, round advance and final result. It drives the datapath's reset, enable and select strobes from the datapath status flags and the player's `enter` switch. It sits beside the datapath in `top` and is clocked by `CLOCK_50`.

---
 rtl/genius_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_genius_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/genius_sequencer.sv
// Memory-game control FSM: conditions the enter switch and paces setup, display, entry, check and result.
// Optional enter debounce filter is compiled in with GENIUS_DEBOUNCE_EN.
module genius_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enter,
  input  logic       end_FPGA,
  input  logic       end_User,
  input  logic       end_time,
  input  logic       win,
  input  logic       match,
  output logic       R1,
  output logic       R2,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       SEL,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_INIT       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_PLAY_FPGA  = 3'd2,
    ST_PLAY_USER  = 3'd3,
    ST_CHECK      = 3'd4,
    ST_NEXT_ROUND = 3'd5,
    ST_RESULT     = 3'd6
  } state_t;

  state_t state_r;
  state_t state_next_s;

  logic sync1_r;
  logic sync2_r;
  logic lvl_s;
  logic lvl_d_r;
  logic enter_p_r;

  logic r1_s, r2_s, e1_s, e2_s, e3_s, e4_s, sel_s;
  logic r1_r, r2_r, e1_r, e2_r, e3_r, e4_r, sel_r;

  // Two-flop synchronizer for the asynchronous enter switch.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= enter;
      sync2_r <= sync1_r;
    end
  end

`ifdef GENIUS_DEBOUNCE_EN
  logic [CNT_W-1:0] db_cnt_r;
  logic             db_lvl_r;

  // Debounce filter: the level only changes after DEBOUNCE_CYCLES stable clocks; any bounce restarts the count.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      db_cnt_r <= {CNT_W{1'b0}};
      db_lvl_r <= 1'b0;
    end else if (sync2_r == db_lvl_r) begin
      db_cnt_r <= {CNT_W{1'b0}};
    end else if (db_cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_r <= {CNT_W{1'b0}};
      db_lvl_r <= sync2_r;
    end else begin
      db_cnt_r <= db_cnt_r + CNT_W'(1);
    end
  end

  assign lvl_s = db_lvl_r;
`else
  logic unused_cfg_s;

  assign unused_cfg_s = CNT_W[0] ^ DEBOUNCE_CYCLES[0];
  assign lvl_s        = sync2_r;
`endif

  // Rising-edge detector producing a registered one-clock press pulse.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      lvl_d_r   <= 1'b0;
      enter_p_r <= 1'b0;
    end else begin
      lvl_d_r   <= lvl_s;
      enter_p_r <= lvl_s & ~lvl_d_r;
    end
  end

  // State register.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; presses outside SETUP, PLAY_USER and RESULT are simply ignored.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT:       state_next_s = ST_SETUP;
      ST_SETUP:      if (enter_p_r) state_next_s = ST_PLAY_FPGA; else state_next_s = ST_SETUP;
      ST_PLAY_FPGA:  if (end_FPGA)  state_next_s = ST_PLAY_USER; else state_next_s = ST_PLAY_FPGA;
      ST_PLAY_USER: begin
        if (end_time) begin
          state_next_s = ST_RESULT;
        end else if (enter_p_r) begin
          state_next_s = ST_CHECK;
        end else begin
          state_next_s = ST_PLAY_USER;
        end
      end
      ST_CHECK: begin
        if (!match) begin
          state_next_s = ST_RESULT;
        end else if (end_User) begin
          state_next_s = ST_NEXT_ROUND;
        end else begin
          state_next_s = ST_PLAY_USER;
        end
      end
      ST_NEXT_ROUND: if (win)       state_next_s = ST_RESULT; else state_next_s = ST_PLAY_FPGA;
      ST_RESULT:     if (enter_p_r) state_next_s = ST_INIT;   else state_next_s = ST_RESULT;
      default:       state_next_s = ST_INIT;
    endcase
  end

  // Strobe decode of the upcoming state, so the registered strobes line up with state_r.
  always_comb begin
    r1_s  = 1'b0;
    r2_s  = 1'b0;
    e1_s  = 1'b0;
    e2_s  = 1'b0;
    e3_s  = 1'b0;
    e4_s  = 1'b0;
    sel_s = 1'b0;
    case (state_next_s)
      ST_INIT:       begin r1_s = 1'b1; r2_s = 1'b1; end
      ST_SETUP:      e1_s = 1'b1;
      ST_PLAY_FPGA:  e2_s = 1'b1;
      ST_PLAY_USER:  begin e3_s = 1'b1; sel_s = 1'b1; end
      ST_CHECK:      sel_s = 1'b1;
      ST_NEXT_ROUND: begin e4_s = 1'b1; r2_s = 1'b1; end
      ST_RESULT:     sel_s = 1'b1;
      default:       r1_s = 1'b0;
    endcase
  end

  // Output strobe registers; reset value equals the INIT decode.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r1_r  <= 1'b1;
      r2_r  <= 1'b1;
      e1_r  <= 1'b0;
      e2_r  <= 1'b0;
      e3_r  <= 1'b0;
      e4_r  <= 1'b0;
      sel_r <= 1'b0;
    end else begin
      r1_r  <= r1_s;
      r2_r  <= r2_s;
      e1_r  <= e1_s;
      e2_r  <= e2_s;
      e3_r  <= e3_s;
      e4_r  <= e4_s;
      sel_r <= sel_s;
    end
  end

  assign R1    = r1_r;
  assign R2    = r2_r;
  assign E1    = e1_r;
  assign E2    = e2_r;
  assign E3    = e3_r;
  assign E4    = e4_r;
  assign SEL   = sel_r;
  assign state = state_r;

endmodule

// File: tb/tb_genius_sequencer.sv
// Directed bench for genius_sequencer; works with and without GENIUS_DEBOUNCE_EN (DEBOUNCE_CYCLES=4).
module tb_genius_sequencer;

`ifdef GENIUS_DEBOUNCE_EN
  localparam int ENTER_LAT = 7;
`else
  localparam int ENTER_LAT = 3;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       enter    = 1'b0;
  logic       end_FPGA = 1'b0;
  logic       end_User = 1'b0;
  logic       end_time = 1'b0;
  logic       win      = 1'b0;
  logic       match    = 1'b0;
  logic       R1, R2, E1, E2, E3, E4, SEL;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  genius_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .enter    (enter),
    .end_FPGA (end_FPGA),
    .end_User (end_User),
    .end_time (end_time),
    .win      (win),
    .match    (match),
    .R1       (R1),
    .R2       (R2),
    .E1       (E1),
    .E2       (E2),
    .E3       (E3),
    .E4       (E4),
    .SEL      (SEL),
    .state    (state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Raise enter and wait until the press pulse is present; the next edge consumes it.
  task automatic press();
    enter = 1'b1;
    repeat (ENTER_LAT) tick();
  endtask

  task automatic release_enter();
    enter = 1'b0;
    repeat (ENTER_LAT + 2) tick();
  endtask

  initial begin
    #2 reset = 1'b0;
    tick(); tick();
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_R1", {7'd0, R1}, 8'd1);
    chk("rst_R2", {7'd0, R2}, 8'd1);
    chk("rst_E", {4'd0, E1, E2, E3, E4}, 8'd0);
    chk("rst_SEL", {7'd0, SEL}, 8'd0);
    reset = 1'b1;
    tick();
    chk("setup_state", {5'd0, state}, 8'd1);
    chk("setup_E1", {7'd0, E1}, 8'd1);
    chk("setup_R1", {7'd0, R1}, 8'd0);

    // Normal round
    press();
    chk("setup_wait", {5'd0, state}, 8'd1);
    tick();
    chk("fpga_state", {5'd0, state}, 8'd2);
    chk("fpga_E2_SEL", {6'd0, E2, SEL}, 8'd2);
    release_enter();
    chk("fpga_hold", {5'd0, state}, 8'd2);
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    chk("user_state", {5'd0, state}, 8'd3);
    chk("user_E3_SEL", {6'd0, E3, SEL}, 8'd3);
    match = 1'b1; end_User = 1'b1;
    press();
    chk("user_wait", {5'd0, state}, 8'd3);
    tick();
    chk("check_state", {5'd0, state}, 8'd4);
    chk("check_SEL_E3", {6'd0, SEL, E3}, 8'd2);
    tick();
    chk("next_state", {5'd0, state}, 8'd5);
    chk("next_E4_R2", {6'd0, E4, R2}, 8'd3);
    tick();
    chk("round2_state", {5'd0, state}, 8'd2);
    chk("round2_E4", {7'd0, E4}, 8'd0);
    end_User = 1'b0;
    release_enter();

    // Partial entry returns to PLAY_USER; a held enter does not repeat
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    press();
    tick();
    chk("partial_check", {5'd0, state}, 8'd4);
    tick();
    chk("partial_back", {5'd0, state}, 8'd3);
    repeat (4) tick();
    chk("held_no_repeat", {5'd0, state}, 8'd3);
    release_enter();

    // Wrong entry
    match = 1'b0;
    press();
    tick();
    chk("wrong_check", {5'd0, state}, 8'd4);
    tick();
    chk("wrong_result", {5'd0, state}, 8'd6);
    chk("wrong_SEL", {7'd0, SEL}, 8'd1);
    release_enter();
    chk("result_hold", {5'd0, state}, 8'd6);
    press();
    tick();
    chk("result_init", {5'd0, state}, 8'd0);
    chk("result_init_R1", {7'd0, R1}, 8'd1);
    tick();
    chk("init_setup", {5'd0, state}, 8'd1);
    release_enter();

    // Timeout wins over a same-cycle press
    press();
    tick();
    release_enter();
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    chk("to_user", {5'd0, state}, 8'd3);
    match = 1'b1;
    press();
    end_time = 1'b1;
    tick();
    end_time = 1'b0;
    chk("timeout_result", {5'd0, state}, 8'd6);
    tick();
    chk("timeout_stay", {5'd0, state}, 8'd6);
    release_enter();
    press();
    tick();
    tick();
    release_enter();
    chk("to_setup", {5'd0, state}, 8'd1);

    // Win after the last round
    press();
    tick();
    release_enter();
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    match = 1'b1; end_User = 1'b1; win = 1'b1;
    press();
    tick();
    chk("win_check", {5'd0, state}, 8'd4);
    tick();
    chk("win_next_E4", {7'd0, E4}, 8'd1);
    tick();
    chk("win_result", {5'd0, state}, 8'd6);
    chk("win_E4_off", {7'd0, E4}, 8'd0);
    match = 1'b0; end_User = 1'b0; win = 1'b0;
    release_enter();
    press();
    tick();
    tick();
    release_enter();
    press();
    tick();
    release_enter();
    chk("drop_pre", {5'd0, state}, 8'd2);

    // Press during PLAY_FPGA is dropped
    press();
    tick();
    tick();
    chk("drop_press", {5'd0, state}, 8'd2);
    release_enter();
    chk("drop_after", {5'd0, state}, 8'd2);

    // Asynchronous reset in PLAY_USER
    end_FPGA = 1'b1;
    tick();
    end_FPGA = 1'b0;
    chk("pre_reset", {5'd0, state}, 8'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_state", {5'd0, state}, 8'd0);
    chk("mid_rst_R", {6'd0, R1, R2}, 8'd3);
    chk("mid_rst_E3", {7'd0, E3}, 8'd0);
    tick();
    reset = 1'b1;
    chk("rel_state", {5'd0, state}, 8'd0);
    tick();
    tick();
    chk("rel_setup", {5'd0, state}, 8'd1);

`ifdef GENIUS_DEBOUNCE_EN
    // Bouncing enter never yields a pulse; a stable one yields exactly one after 7 clocks
    for (int i = 0; i < 10; i++) begin
      enter = ~enter;
      tick();
      chk("bounce_p", {7'd0, dut.enter_p_r}, 8'd0);
      tick();
      chk("bounce_p", {7'd0, dut.enter_p_r}, 8'd0);
    end
    enter = 1'b0;
    repeat (8) tick();
    chk("bounce_state", {5'd0, state}, 8'd1);
    enter = 1'b1;
    repeat (6) tick();
    chk("db_p_early", {7'd0, dut.enter_p_r}, 8'd0);
    tick();
    chk("db_p_on", {7'd0, dut.enter_p_r}, 8'd1);
    chk("db_state_wait", {5'd0, state}, 8'd1);
    tick();
    chk("db_p_off", {7'd0, dut.enter_p_r}, 8'd0);
    chk("db_state", {5'd0, state}, 8'd2);
    repeat (10) tick();
    chk("db_single", {5'd0, state}, 8'd2);
    release_enter();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
